// File: rtl/prbs4_pkg.sv
// Shared definitions for the PRBS4 (x^4+x+1) generator/checker pair.
// Tap positions and the period live here so both ends agree on the polynomial.
package prbs4_pkg;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } prbs4_state_e;

  localparam int unsigned PRBS4_W      = 4;
  localparam int unsigned TAP_A        = 3;
  localparam int unsigned TAP_B        = 2;
  localparam int unsigned PRBS4_PERIOD = 15;

endpackage

// File: rtl/prbs4_next.sv
// PRBS4 prediction and shift step, shared with the generator.
// Generator: use_pred=1 gives s' = {s[2:0], s[3]^s[2]}; checker selects received or predicted bit.
module prbs4_next
  import prbs4_pkg::*;
(
  input  logic [PRBS4_W-1:0] cur,
  input  logic               in_bit,
  input  logic               use_pred,
  output logic               pred,
  output logic [PRBS4_W-1:0] nxt
);

  always_comb begin
    pred = cur[TAP_A] ^ cur[TAP_B];
    nxt  = {cur[PRBS4_W-2:0], (use_pred ? pred : in_bit)};
  end

endmodule

// File: rtl/prbs4_checker.sv
// Self-synchronising PRBS4 receiver: hunts for four bits, confirms LOCK_CNT predictions,
// then flywheels on its own prediction and counts mismatches until LOSS_THRESH in a row.
module prbs4_checker
  import prbs4_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 8,
  parameter int unsigned LOSS_THRESH = 3,
  parameter int unsigned ERR_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               clr_cnt,
  output logic               locked,
  output logic               err_pulse,
  output logic [ERR_W-1:0]   err_count,
  output logic [PRBS4_W-1:0] hist
);

  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW  = $clog2(LOSS_THRESH + 1);

  prbs4_state_e       state_q, state_d;
  logic [2:0]         fill_q, fill_d;
  logic [MatchW-1:0]  match_q, match_d;
  logic [MissW-1:0]   miss_q, miss_d;
  logic [PRBS4_W-1:0] hist_q, hist_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic               pred;
  logic [PRBS4_W-1:0] hist_nxt;

  // Once locked the received bit is ignored, so one corrupted bit costs exactly one error.
  prbs4_next u_next (
    .cur      (hist_q),
    .in_bit   (in_bit),
    .use_pred (state_q == LOCKED),
    .pred     (pred),
    .nxt      (hist_nxt)
  );

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    hist_d      = hist_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          hist_d = hist_nxt;
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd3) begin
            state_d = SYNC;
            match_d = '0;
          end
        end

        SYNC: begin
          hist_d = hist_nxt;
          // An all-zero history is the LFSR lock-up state and predicts nothing useful.
          if (hist_q == '0) begin
            match_d = '0;
          end else if (in_bit == pred) begin
            match_d = match_q + MatchW'(1);
          end else begin
            match_d = '0;
          end
          if (match_d == MatchW'(LOCK_CNT)) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
            match_d  = '0;
            miss_d   = '0;
          end
        end

        LOCKED: begin
          hist_d = hist_nxt;
          if (in_bit == pred) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            miss_d = miss_q + MissW'(1);
            if (miss_d == MissW'(LOSS_THRESH)) begin
              state_d  = HUNT;
              fill_d   = '0;
              miss_d   = '0;
              locked_d = 1'b0;
            end
          end
        end

        default: begin
          state_d  = HUNT;
          fill_d   = '0;
          locked_d = 1'b0;
        end
      endcase
    end

    if (clr_cnt) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      hist_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      hist_q      <= hist_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
  assign hist      = hist_q;

endmodule

// File: tb/tb_prbs4_checker.sv
// Directed bench for prbs4_checker driven by the seed-1111 reference stream.
module tb_prbs4_checker;
  import prbs4_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_count;
  logic [3:0]  hist;

  int checks = 0;
  int errors = 0;
  int pos = 0;
  logic [14:0] ref_v = 15'b111100010011010;

  always #5 clk = ~clk;

  prbs4_checker #(
    .LOCK_CNT    (8),
    .LOSS_THRESH (3),
    .ERR_W       (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .hist      (hist)
  );

  function automatic logic ref_bit(input int i);
    int k;
    k = 14 - (i % int'(PRBS4_PERIOD));
    return ref_v[k];
  endfunction

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic v, input logic b, input logic clr, input logic rst);
    reset    = rst;
    in_valid = v;
    in_bit   = b;
    clr_cnt  = clr;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic send(input logic inv);
    cycle(1'b1, ref_bit(pos) ^ inv, 1'b0, 1'b0);
    pos++;
  endtask

  task automatic test_reset;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL reset_locked got %b expected 0", locked);
    end
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_err_pulse got %b expected 0", err_pulse);
    end
    checks++;
    if (err_count !== 16'd0) begin
      errors++; $display("FAIL reset_err_count got %0d expected 0", err_count);
    end
    checks++;
    if (hist !== 4'b0000) begin
      errors++; $display("FAIL reset_hist got %b expected 0000", hist);
    end
  endtask

  task automatic test_clean_lock;
    logic early, drop, pulse;
    early = 1'b0; drop = 1'b0; pulse = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    pos = 0;
    for (int i = 0; i < 11; i++) begin
      send(1'b0);
      early |= locked;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL lock_early got %b expected 0", early);
    end
    send(1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL lock_bit11 got %b expected 1", locked);
    end
    checks++;
    if (hist !== 4'b0011) begin
      errors++; $display("FAIL lock_hist got %b expected 0011", hist);
    end
    for (int i = 12; i < 60; i++) begin
      send(1'b0);
      drop  |= ~locked;
      pulse |= err_pulse;
    end
    checks++;
    if (drop !== 1'b0 || pulse !== 1'b0) begin
      errors++; $display("FAIL clean_run drop=%b pulse=%b expected 0 0", drop, pulse);
    end
    checks++;
    if (err_count !== 16'd0) begin
      errors++; $display("FAIL clean_count got %0d expected 0", err_count);
    end
    checks++;
    if (hist !== 4'b1010) begin
      errors++; $display("FAIL flywheel_hist got %b expected 1010", hist);
    end
  endtask

  task automatic test_single_error;
    send(1'b1);
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_err pulse=%b count=%0d locked=%b expected 1 1 1",
               err_pulse, err_count, locked);
    end
    send(1'b0);
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++; $display("FAIL single_pulse_width got %b expected 0", err_pulse);
    end
    for (int i = 0; i < 5; i++) send(1'b0);
    checks++;
    if (err_count !== 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_after count=%0d locked=%b expected 1 1", err_count, locked);
    end
  endtask

  task automatic test_loss_of_lock;
    logic early;
    early = 1'b0;
    cycle(1'b1, ref_bit(pos), 1'b1, 1'b0);
    pos++;
    checks++;
    if (err_count !== 16'd0) begin
      errors++; $display("FAIL clr_count got %0d expected 0", err_count);
    end
    send(1'b1);
    send(1'b1);
    checks++;
    if (err_count !== 16'd2 || locked !== 1'b1) begin
      errors++;
      $display("FAIL loss_second count=%0d locked=%b expected 2 1", err_count, locked);
    end
    send(1'b1);
    checks++;
    if (err_count !== 16'd3 || locked !== 1'b0 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL loss_third count=%0d locked=%b pulse=%b expected 3 0 1",
               err_count, locked, err_pulse);
    end
    for (int i = 0; i < 11; i++) begin
      send(1'b0);
      early |= locked;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL relock_early got %b expected 0", early);
    end
    send(1'b0);
    checks++;
    if (locked !== 1'b1 || err_count !== 16'd3) begin
      errors++;
      $display("FAIL relock locked=%b count=%0d expected 1 3", locked, err_count);
    end
  endtask

  task automatic test_all_zero;
    logic any_lock;
    any_lock = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      any_lock |= locked;
    end
    checks++;
    if (any_lock !== 1'b0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL all_zero locked=%b count=%0d expected 0 0", any_lock, err_count);
    end
    checks++;
    if (hist !== 4'b0000) begin
      errors++; $display("FAIL all_zero_hist got %b expected 0000", hist);
    end
  endtask

  task automatic test_stall;
    logic early, pulse;
    early = 1'b0; pulse = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    pos = 0;
    for (int i = 0; i < 11; i++) begin
      send(1'b0);
      early |= locked;
      cycle(1'b0, ~ref_bit(pos), 1'b0, 1'b0);
      early |= locked;
      pulse |= err_pulse;
    end
    checks++;
    if (early !== 1'b0 || pulse !== 1'b0) begin
      errors++; $display("FAIL stall_early locked=%b pulse=%b expected 0 0", early, pulse);
    end
    send(1'b0);
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL stall_lock got %b expected 1", locked);
    end
    cycle(1'b0, ~ref_bit(pos), 1'b0, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_pulse !== 1'b0 || err_count !== 16'd0 || hist !== 4'b0011) begin
      errors++;
      $display("FAIL stall_hold locked=%b pulse=%b count=%0d hist=%b expected 1 0 0 0011",
               locked, err_pulse, err_count, hist);
    end
  endtask

  task automatic test_clr_with_error;
    send(1'b1);
    checks++;
    if (err_count !== 16'd1) begin
      errors++; $display("FAIL pre_clr_count got %0d expected 1", err_count);
    end
    send(1'b0);
    cycle(1'b1, ~ref_bit(pos), 1'b1, 1'b0);
    pos++;
    checks++;
    if (err_count !== 16'd0 || err_pulse !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_err count=%0d pulse=%b locked=%b expected 0 1 1",
               err_count, err_pulse, locked);
    end
  endtask

  task automatic test_reset_mid;
    logic early;
    early = 1'b0;
    send(1'b1);
    send(1'b0);
    send(1'b1);
    checks++;
    if (err_count !== 16'd2 || locked !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset count=%0d locked=%b expected 2 1", err_count, locked);
    end
    cycle(1'b1, ref_bit(pos), 1'b0, 1'b1);
    pos++;
    checks++;
    if (locked !== 1'b0 || err_count !== 16'd0 || err_pulse !== 1'b0 || hist !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset locked=%b count=%0d pulse=%b hist=%b expected 0 0 0 0000",
               locked, err_count, err_pulse, hist);
    end
    for (int i = 0; i < 11; i++) begin
      send(1'b0);
      early |= locked;
    end
    send(1'b0);
    checks++;
    if (early !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_lock early=%b locked=%b expected 0 1", early, locked);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_loss_of_lock();
    test_all_zero();
    test_stall();
    test_clr_with_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
